data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the load/store path: accepts word-aligned requests with byte enables from the load/store unit, performs byte-masked writes and registered reads on an internal word array, and signals completion with a one-cycle `mem_ready` pulse after a programmable number of wait states. It sits between the MEM stage and on-chip data storage. The pipeline stalls on `!mem_ready` while a request is outstanding.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two, at least 2.
- `WAIT_STATES`, default 0: extra cycles inserted between accept and response; range 0–15.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `mem_enable`  in  1  request valid; held until `mem_ready` is seen.
- `mem_we`  in  1  1 = write, 0 = read; qualified by `mem_enable`.
- `mem_address`  in  32  byte address; bits [1:0] ignored.
- `mem_write_data`  in  32  write data, already lane-aligned.
- `mem_byte_enable`  in  4  per-byte write mask; bit i covers bits [8i+7:8i].
- `mem_read_data`  out  32  registered read word; valid in the cycle `mem_ready`=1 for a read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_error`  out  1  out-of-range flag, asserted with `mem_ready` (see Configuration).

## Operation
- **Word index:** `mem_address[AW+1:2]`, where AW = $clog2(DEPTH_WORDS).
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - Accepts when `mem_enable`=1.
  - At the accept edge:
    - write: each lane with its byte-enable bit set is written from `mem_write_data`; other lanes are unchanged.
    - read: the whole word is captured into `rdata_q`.
  - Next state is WAIT with `cnt`=WAIT_STATES-1 if WAIT_STATES>0, otherwise RESP.
- **WAIT:** decrements `cnt` each cycle; moves to RESP when `cnt`=0.
- **RESP:**
  - `mem_ready`=1 for exactly this cycle.
  - `mem_enable`, which is still held by the initiator, is ignored.
  - Always returns to IDLE.
- **Register and lane rules:**
  - `mem_read_data` = `rdata_q`. It holds its value between reads and is not updated by writes.
  - Write with `mem_byte_enable`=4'b0000: array unchanged, full handshake still performed.
  - `mem_byte_enable` is ignored for reads.
- **Request stability:** address, data, enables and `mem_we` are sampled only at the accept edge. Changes while the FSM is in WAIT or RESP have no effect.
- **Reset** (`rst_n`=0 at a rising edge):
  - state → IDLE; `cnt`, `rdata_q`, `mem_ready` and `mem_error` → 0.
  - Array contents are not reset.
  - A write committed at an earlier accept edge stays committed.
  - A reset in WAIT or RESP aborts the response, so no `mem_ready` is produced.

## Timing
- Request first seen in cycle N, with the FSM in IDLE: accepted at the end of N; `mem_ready` is high in cycle N+1+WAIT_STATES.
- Earliest next accept: cycle N+2+WAIT_STATES, i.e. one access per WAIT_STATES+2 cycles.
- Read-after-write to the same word in the next access returns the new data; the write is already committed at the earlier accept edge.
- All outputs are registered, with no combinational input→output paths.
- Reset values: `mem_read_data`=32'h0, `mem_ready`=0, `mem_error`=0.

## Configuration
- Macro: `DMEM_BOUNDS_CHECK_EN`.
- **Defined:**
  - A request with `mem_address` ≥ DEPTH_WORDS*4 is out of range.
  - The out-of-range flag is latched at accept; `mem_error`=1 during RESP together with `mem_ready`.
  - Out-of-range write: array unchanged.
  - Out-of-range read: `rdata_q` ← 32'h0.
  - Timing is identical to an in-range access.
- **Undefined:**
  - Upper address bits above AW+1 are ignored, so addresses alias modulo DEPTH_WORDS*4.
  - `mem_error` is tied to 0.

## Test plan
- **Basic latency:** WAIT_STATES=0. Write 0x12345678 to 0x40 with BE 1111, then read 0x40 → `mem_ready` one cycle after each accept; read returns 0x12345678.
- **Byte-masked write:** word 0x40 holds 0x12345678. Write 0x0000AB00 with BE 0010 → read 0x40 returns 0x1234AB78. Write 0xFFFFFFFF with BE 0000 → read still returns 0x1234AB78.
- **Wait states:** WAIT_STATES=3. Request in cycle 0 → `mem_ready` only in cycle 4. Request held through cycle 4 → not re-accepted; next accept no earlier than cycle 5.
- **Low address bits ignored:** read 0x43 → same word as 0x40. Changing `mem_address` and `mem_we` during WAIT → no effect on the result.
- **Reset mid-operation:** WAIT_STATES=3, read accepted, `rst_n`=0 in the first WAIT cycle → no `mem_ready`; `mem_read_data`=0; FSM accepts a new request in the cycle after reset release.
- **Bounds check:** DEPTH_WORDS=1024, `DMEM_BOUNDS_CHECK_EN` defined. Write 0xDEADBEEF to 0x1000 → `mem_ready`=1 and `mem_error`=1; a read of 0x0 is unchanged. Without the macro, the same write lands in word 0 and `mem_error` stays 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the load/store path. A request is accepted in IDLE.
// On that same clock edge a write updates its enabled byte lanes, or a read
// captures the whole word into rdata_q. After WAIT_STATES extra cycles the
// block drives a one-cycle mem_ready pulse in the RESP state.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   WAIT_STATES  extra cycles between accept and response (0..15)
//
// Ports
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   mem_enable       request valid, held by the initiator until mem_ready
//   mem_we           1 = write, 0 = read
//   mem_address      byte address; bits [1:0] ignored
//   mem_write_data   lane-aligned write data
//   mem_byte_enable  per-byte write mask (ignored for reads)
//   mem_read_data    registered read word, valid with mem_ready on a read
//   mem_ready        one-cycle completion pulse
//   mem_error        out-of-range flag, asserted together with mem_ready
//
// Configuration macro
//   DMEM_BOUNDS_CHECK_EN  When defined, addresses >= DEPTH_WORDS*4 are out of
//                         range: writes are dropped, reads return 0 and
//                         mem_error is raised with mem_ready. When undefined,
//                         upper address bits alias and mem_error stays 0.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_enable,
  input  logic        mem_we,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("DEPTH_WORDS must be a power of two and at least 2");
  end
  if (WAIT_STATES > 15) begin : g_bad_wait
    $error("WAIT_STATES must be in the range 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          error_q, error_d;

  logic [31:0]   mem_array [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic          accept;
  logic          in_range;
  logic          unused_addr;

  // Requests are only looked at in IDLE; a request still held during RESP is
  // the one already being answered and must not be taken again.
  assign accept   = (state_q == S_IDLE) && mem_enable;
  assign word_idx = mem_address[AW+1:2];

  // Low bits are ignored by design; upper bits alias when bounds checking is off.
  assign unused_addr = ^mem_address;

`ifdef DMEM_BOUNDS_CHECK_EN
  logic err_lat_q, err_lat_d;

  assign in_range  = ({1'b0, mem_address} < (33'(DEPTH_WORDS) * 33'd4));
  // The range flag is frozen at accept so later address changes cannot alter it.
  assign err_lat_d = accept ? !in_range : err_lat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_lat_q <= 1'b0;
    end else begin
      err_lat_q <= err_lat_d;
    end
  end
`else
  assign in_range = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mem_enable) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: outputs are registered, so they are computed from the state
  // being entered and appear in the cycle the FSM is actually in RESP.
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_d = (state_d == S_RESP);
    rdata_d = rdata_q;
    if (accept && !mem_we) begin
      rdata_d = in_range ? mem_array[word_idx] : 32'h0;
    end
`ifdef DMEM_BOUNDS_CHECK_EN
    error_d = (state_d == S_RESP) && err_lat_d;
`else
    error_d = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // Word array: byte-masked write committed at the accept edge
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; clearing it would turn a RAM into
  // thousands of resettable flops, and its contents must survive rst_n anyway.
  always_ff @(posedge clk) begin
    if (rst_n && accept && mem_we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_byte_enable[i]) begin
          mem_array[word_idx][8*i +: 8] <= mem_write_data[8*i +: 8];
        end
      end
    end
  end

  assign mem_read_data = rdata_q;
  assign mem_ready     = ready_q;
  assign mem_error     = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Two responders share one clock: u_dut_ws0 (WAIT_STATES=0) and u_dut_ws3
// (WAIT_STATES=3), both with DEPTH_WORDS=1024. A behavioural model keeps a
// plain word array per instance and the expected read register; byte merges
// and aliasing are computed arithmetically from the address and mask.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int N     = 2;
  localparam int DEPTH = 1024;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n           [N];
  logic        mem_enable      [N];
  logic        mem_we          [N];
  logic [31:0] mem_address     [N];
  logic [31:0] mem_write_data  [N];
  logic [3:0]  mem_byte_enable [N];
  logic [31:0] mem_read_data   [N];
  logic        mem_ready       [N];
  logic        mem_error       [N];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl_mem [N][DEPTH];
  logic [31:0] mdl_rd  [N];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
    .clk             (clk),
    .rst_n           (rst_n[0]),
    .mem_enable      (mem_enable[0]),
    .mem_we          (mem_we[0]),
    .mem_address     (mem_address[0]),
    .mem_write_data  (mem_write_data[0]),
    .mem_byte_enable (mem_byte_enable[0]),
    .mem_read_data   (mem_read_data[0]),
    .mem_ready       (mem_ready[0]),
    .mem_error       (mem_error[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut_ws3 (
    .clk             (clk),
    .rst_n           (rst_n[1]),
    .mem_enable      (mem_enable[1]),
    .mem_we          (mem_we[1]),
    .mem_address     (mem_address[1]),
    .mem_write_data  (mem_write_data[1]),
    .mem_byte_enable (mem_byte_enable[1]),
    .mem_read_data   (mem_read_data[1]),
    .mem_ready       (mem_ready[1]),
    .mem_error       (mem_error[1])
  );

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model of the address rules: word = (addr / 4) mod DEPTH, out of range only
  // when bounds checking is built in and the byte address is beyond the array.
  function automatic bit mdl_oor(input logic [31:0] a);
    return BOUNDS_EN && (a >= 32'(DEPTH * 4));
  endfunction

  function automatic int mdl_word(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // Model update done at the accept point, then the handshake is checked:
  // latency, data, error flag, and that the pulse lasts one cycle.
  task automatic access(input int k, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input bit scramble,
                        output logic [31:0] rd_out, output logic err_out);
    int          cyc;
    bit          got;
    bit          oor;
    int          w;
    logic [31:0] mask;
    oor  = mdl_oor(addr);
    w    = mdl_word(addr);
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (we) begin
      if (!oor) mdl_mem[k][w] = (mdl_mem[k][w] & ~mask) | (wdata & mask);
    end else begin
      mdl_rd[k] = oor ? 32'h0 : mdl_mem[k][w];
    end

    mem_enable[k]      = 1'b1;
    mem_we[k]          = we;
    mem_address[k]     = addr;
    mem_write_data[k]  = wdata;
    mem_byte_enable[k] = be;
    @(posedge clk);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_ready[k]) begin
        got = 1'b1;
      end else if (scramble) begin
        mem_address[k]     = $urandom;
        mem_we[k]          = ~mem_we[k];
        mem_write_data[k]  = $urandom;
        mem_byte_enable[k] = 4'($urandom);
      end
    end
    check("latency", 32'(cyc), 32'(ws_of(k) + 1));
    rd_out  = mem_read_data[k];
    err_out = mem_error[k];
    check("rdata", rd_out, mdl_rd[k]);
    check("error", 32'(err_out), 32'(oor));
    mem_enable[k] = 1'b0;
    @(negedge clk);
    check("ready_pulse", 32'(mem_ready[k]), 32'h0);
  endtask

  // Request held high continuously: pulses must be WAIT_STATES+2 apart, the
  // held request at the end of RESP must not be taken a second time.
  task automatic back_to_back(input int k, input logic [31:0] addr);
    int          ws;
    int          last;
    logic [31:0] exp;
    ws   = ws_of(k);
    last = 3 * ws + 5;
    exp  = mdl_mem[k][mdl_word(addr)];
    mem_enable[k]  = 1'b1;
    mem_we[k]      = 1'b0;
    mem_address[k] = addr;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      check("b2b_ready", 32'(mem_ready[k]), 32'((c % (ws + 2)) == (ws + 1)));
    end
    mem_enable[k] = 1'b0;
    mdl_rd[k]     = exp;
    @(negedge clk);
    check("b2b_idle", 32'(mem_ready[k]), 32'h0);
    check("b2b_rdata", mem_read_data[k], exp);
  endtask

  // Reset asserted during the first WAIT cycle of a read.
  task automatic reset_mid(input int k);
    logic [31:0] d;
    logic        e;
    mem_enable[k]  = 1'b1;
    mem_we[k]      = 1'b0;
    mem_address[k] = 32'h8;
    @(posedge clk);
    @(negedge clk);
    check("rst_pre_ready", 32'(mem_ready[k]), 32'h0);
    rst_n[k]      = 1'b0;
    mem_enable[k] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rst_no_ready", 32'(mem_ready[k]), 32'h0);
      check("rst_rdata", mem_read_data[k], 32'h0);
      check("rst_error", 32'(mem_error[k]), 32'h0);
    end
    mdl_rd[k] = 32'h0;
    rst_n[k]  = 1'b1;
    access(k, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, d, e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] w0_before;
    logic [31:0] addr;

    for (int k = 0; k < N; k++) begin
      rst_n[k]           = 1'b0;
      mem_enable[k]      = 1'b0;
      mem_we[k]          = 1'b0;
      mem_address[k]     = 32'h0;
      mem_write_data[k]  = 32'h0;
      mem_byte_enable[k] = 4'h0;
      mdl_rd[k]          = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("reset_rdata", mem_read_data[k], 32'h0);
      check("reset_ready", 32'(mem_ready[k]), 32'h0);
      check("reset_error", 32'(mem_error[k]), 32'h0);
      rst_n[k] = 1'b1;
    end
    @(negedge clk);

    // Give words 0..15 known contents so later reads compare against the model.
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 16; i++) begin
        access(k, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, d, e);
      end
    end

    for (int k = 0; k < N; k++) begin
      access(k, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0, d, e);
      access(k, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, d, e);
      check("basic_rd", d, 32'h12345678);
      access(k, 1'b1, 32'h40, 32'h0000AB00, 4'b0010, 1'b0, d, e);
      access(k, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, d, e);
      check("mask_rd", d, 32'h1234AB78);
      access(k, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 1'b0, d, e);
      check("be0_rd_hold", d, 32'h1234AB78);
      access(k, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, d, e);
      check("be0_rd", d, 32'h1234AB78);
      access(k, 1'b0, 32'h43, 32'h0, 4'hF, 1'b1, d, e);
      check("lowbits_rd", d, 32'h1234AB78);
      back_to_back(k, 32'h40);
    end

    // Out-of-range write against the aliasing word 0.
    w0_before = mdl_mem[0][0];
    access(0, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 1'b0, d, e);
    check("oob_error", 32'(e), 32'(BOUNDS_EN));
    access(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, d, e);
    check("oob_word0", d, BOUNDS_EN ? w0_before : 32'hDEADBEEF);

    for (int n = 0; n < 240; n++) begin
      addr = ((($urandom % 4) == 0) ? (32'($urandom_range(1, 7)) << 12) : 32'h0)
           | (32'($urandom % 16) << 2) | 32'($urandom % 4);
      access(n % 2, 1'($urandom), addr, $urandom, 4'($urandom), 1'($urandom), d, e);
      if (($urandom % 4) == 0) @(negedge clk);
    end

    access(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, d, e);
    check("pre_reset_rd", d, 32'h1234AB78);
    reset_mid(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
